// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// ALUOp / mux select codes and the packed control vector.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG   = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multicycle FSM (master) and the datapath
// (slave): opcode/ready in, every enable and select out.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       aluop1;
  logic       aluop0;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, illegal_op, state
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, illegal_op, state
  );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational state -> control vector decode. i_ready only gates the
// FETCH instruction/PC load; everything else is a pure function of state.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memread  = 1'b1;
        o_ctrl.alusrcb  = ALUB_FOUR;
        o_ctrl.aluop    = ALUOP_ADD;
        o_ctrl.pcsource = PCSRC_ALU;
        o_ctrl.irwrite  = i_ready;
        o_ctrl.pcwrite  = i_ready;
      end
      S_DECODE: begin
        o_ctrl.alusrcb = ALUB_IMMSH;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_REXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUB_REG;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = 1'b1;
      end
      S_IEXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_IWB: begin
        o_ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrca     = 1'b1;
        o_ctrl.alusrcb     = ALUB_REG;
        o_ctrl.aluop       = ALUOP_SUB;
        o_ctrl.pcwritecond = 1'b1;
        o_ctrl.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pcwrite  = 1'b1;
        o_ctrl.pcsource = PCSRC_JUMP;
      end
      // 12..15 are unreachable encodings; flag them and drive nothing else
      default: o_ctrl.illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: state register plus next-state logic,
// with the control outputs decoded from state by mc_output_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  state_t r_state;
  state_t w_next;
  logic   w_ready;
  logic   w_bad_op;
  ctrl_t  w_ctrl;

  // Without the handshake every memory wait completes in one cycle.
  assign w_ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = S_FETCH;
    w_bad_op = 1'b0;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_REXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_IEXEC;
          default: begin
            w_next   = S_FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      // IR is frozen here, so op still holds the lw/sw that got us here
      S_MEMADR: w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_IEXEC:  w_next = S_IWB;
      S_IWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .i_state (r_state),
    .i_ready (w_ready),
    .o_ctrl  (w_ctrl)
  );

  assign bus.pcwrite     = w_ctrl.pcwrite;
  assign bus.pcwritecond = w_ctrl.pcwritecond;
  assign bus.iord        = w_ctrl.iord;
  assign bus.memread     = w_ctrl.memread;
  assign bus.memwrite    = w_ctrl.memwrite;
  assign bus.irwrite     = w_ctrl.irwrite;
  assign bus.memtoreg    = w_ctrl.memtoreg;
  assign bus.regdst      = w_ctrl.regdst;
  assign bus.regwrite    = w_ctrl.regwrite;
  assign bus.alusrca     = w_ctrl.alusrca;
  assign bus.alusrcb     = w_ctrl.alusrcb;
  assign bus.pcsource    = w_ctrl.pcsource;
  assign bus.aluop1      = w_ctrl.aluop[1];
  assign bus.aluop0      = w_ctrl.aluop[0];
  assign bus.illegal_op  = w_ctrl.illegal_op | w_bad_op;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cases plus random instruction streams
// with random memory waits, checked against per-instruction expected traces.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   exp_store = 0;
  int   exp_rw = 0;
  int   n_store = 0;
  int   n_rw = 0;

  multicycle_control_if bus ();

  multicycle_control #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // observed commits: a store lands on memwrite&&mem_ready, a reg write on regwrite
  always @(posedge clk) begin
    if (bus.memwrite && bus.mem_ready) n_store <= n_store + 1;
    if (bus.regwrite) n_rw <= n_rw + 1;
  end

  logic [16:0] obs;
  assign obs = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
                bus.alusrcb, bus.pcsource, bus.aluop1, bus.aluop0, bus.illegal_op};

  typedef struct {
    state_t ph;
    logic   rdy;
  } step_t;

  step_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // What the datapath should see while the instruction is in phase ph.
  function automatic logic [16:0] exp_out(input state_t ph, input logic rdy, input logic [5:0] op);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, pcs, aop;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (ph)
      S_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      S_DECODE: begin asb = 2'b11; ill = !op_supported(op); end
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mr = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mw = 1; iord = 1; end
      S_REXEC:  begin asa = 1; aop = 2'b10; end
      S_RWB:    begin rw = 1; rd = 1; end
      S_IEXEC:  begin asa = 1; asb = 2'b10; end
      S_IWB:    begin rw = 1; end
      S_BRANCH: begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      S_JUMP:   begin pw = 1; pcs = 2'b10; end
      default:  ill = 1;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, ill};
  endfunction

  function automatic int pick_wait(input int w);
    if (w >= 0) return w;
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic push_wait(input state_t ph, input int w);
    for (int i = 0; i < w; i++) q.push_back('{ph, 1'b0});
    q.push_back('{ph, 1'b1});
  endtask

  task automatic push_one(input state_t ph);
    q.push_back('{ph, 1'($urandom_range(0, 1))});
  endtask

  // Drive one cycle mid-low-phase, check after settling, before the next rising edge.
  task automatic play(input logic [5:0] op);
    step_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      bus.op = op;
      bus.mem_ready = e.rdy;
      #1;
      chk($sformatf("state_%s", e.ph.name()), 32'(bus.state), 32'(e.ph));
      chk($sformatf("ctrl_%s", e.ph.name()), 32'(obs), 32'(exp_out(e.ph, e.rdy, op)));
      if (e.ph == S_MEMWR && e.rdy) exp_store++;
      if (e.ph == S_MEMWB || e.ph == S_RWB || e.ph == S_IWB) exp_rw++;
    end
  endtask

  // Expected phase trace of one instruction, by instruction class.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    push_wait(S_FETCH, pick_wait(fw));
    push_one(S_DECODE);
    case (op)
      OP_LW:   begin push_one(S_MEMADR); push_wait(S_MEMRD, pick_wait(mw)); push_one(S_MEMWB); end
      OP_SW:   begin push_one(S_MEMADR); push_wait(S_MEMWR, pick_wait(mw)); end
      OP_R:    begin push_one(S_REXEC); push_one(S_RWB); end
      OP_ADDI: begin push_one(S_IEXEC); push_one(S_IWB); end
      OP_BEQ:  push_one(S_BRANCH);
      OP_J:    push_one(S_JUMP);
      default: ;
    endcase
    play(op);
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] o;
    case ($urandom_range(0, 6))
      0: o = OP_R;
      1: o = OP_LW;
      2: o = OP_SW;
      3: o = OP_BEQ;
      4: o = OP_J;
      5: o = OP_ADDI;
      default: begin
        o = 6'($urandom);
        while (op_supported(o)) o = 6'($urandom);
      end
    endcase
    return o;
  endfunction

  int snap_store;
  int snap_rw;

  initial begin
    reset = 1'b1;
    bus.op = OP_R;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_state", 32'(bus.state), 32'(S_FETCH));
    chk("reset_ctrl", 32'(obs), 32'(exp_out(S_FETCH, 1'b0, OP_R)));
    reset = 1'b0;

    // directed: R, lw with 2 MEMRD waits, 3 FETCH waits, beq, j, illegal
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 2);
    run_instr(OP_ADDI, 3, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(OP_SW, 1, 1);

    // reset mid-MEMWR with mem_ready low: the store must be abandoned
    q.push_back('{S_FETCH, 1'b1});
    push_one(S_DECODE);
    push_one(S_MEMADR);
    q.push_back('{S_MEMWR, 1'b0});
    play(OP_SW);
    snap_store = n_store;
    snap_rw = n_rw;
    reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(bus.state), 32'(S_FETCH));
    chk("async_reset_memwrite", 32'(bus.memwrite), 32'd0);
    chk("async_reset_ctrl", 32'(obs), 32'(exp_out(S_FETCH, 1'b0, OP_SW)));
    @(posedge clk); #1;
    chk("reset_hold_state", 32'(bus.state), 32'(S_FETCH));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_no_store", 32'(n_store), 32'(snap_store));
    chk("reset_no_regwrite", 32'(n_rw), 32'(snap_rw));
    chk("post_reset_state", 32'(bus.state), 32'(S_FETCH));
    run_instr(OP_LW, 0, 0);

    // random instruction stream with random memory waits
    for (int n = 0; n < 80; n++) run_instr(rand_op(), -1, -1);

    @(negedge clk);
    chk("store_commits", 32'(n_store), 32'(exp_store));
    chk("regwrite_cycles", 32'(n_rw), 32'(exp_rw));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
